// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - shuffled 52-card deck source for the blackjack round FSM
//
// Purpose:
//   Builds a deck of DECK_SIZE card indices in internal storage (INIT), shuffles
//   it with a Fisher-Yates pass, one swap per cycle, driven by a free-running
//   16-bit Galois LFSR (SHUFFLE), then deals one card per request without
//   repetition until the deck runs out or a reshuffle is requested (IDLE).
//
// Build option:
//   DEALER_FIXED_DECK_EN - when defined, SHUFFLE is skipped and the deck is
//   dealt in identity order 0..DECK_SIZE-1. The LFSR and handshake are unchanged.
//
// Parameters:
//   DECK_SIZE    number of cards (at most 64, indices fit in 6 bits)
//   SEED         LFSR reset value; 0 is replaced by 16'h0001
//
// Ports:
//   CLOCK_50     in   system clock, all state on its rising edge
//   resetn       in   asynchronous active-low reset
//   shuffle_req  in   rebuild and reshuffle request, sampled in IDLE only
//   draw_req     in   one-card request, sampled in IDLE with cards left
//   card         out  last dealt card index, held between strobes
//   card_rank    out  card % 13
//   card_suit    out  card / 13
//   card_valid   out  one-cycle strobe marking a newly dealt card
//   ready        out  IDLE with at least one card left
//   remaining    out  cards not yet dealt
//   empty        out  IDLE with no cards left

module card_dealer #(
  parameter int          DECK_SIZE = 52,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       shuffle_req,
  input  logic       draw_req,
  output logic [5:0] card,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic       card_valid,
  output logic       ready,
  output logic [5:0] remaining,
  output logic       empty
);

  // An all-zero Galois LFSR would lock up, so a zero seed is nudged to 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [5:0]  LAST_IDX  = 6'(DECK_SIZE - 1);
  localparam logic [5:0]  FULL_CNT  = 6'(DECK_SIZE);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_IDLE    = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [5:0]  i;
  logic [5:0]  ptr;
  logic [5:0]  j;
  logic [5:0]  deck [0:DECK_SIZE-1];

  // Swap partner: floor(lfsr * (i+1) / 2^16). Because lfsr < 2^16 this is
  // always in 0..i, so no rejection or modulo step is needed.
  assign j = 6'((22'(lfsr) * 22'(i + 6'd1)) >> 16);

  assign card_rank = 4'(card % 6'd13);
  assign card_suit = 2'(card / 6'd13);

  // Deck storage has no reset: INIT rewrites every entry before any deal,
  // so whatever a reset interrupts is simply overwritten.
  always_ff @(posedge CLOCK_50) begin
    if (state == ST_INIT) begin
      deck[i] <= i;
    end else if (state == ST_SHUFFLE) begin
      // Both writes read the pre-edge contents, so this is a true swap;
      // j == i writes the same value twice and leaves the entry unchanged.
      deck[i] <= deck[j];
      deck[j] <= deck[i];
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_INIT;
      lfsr       <= SEED_EFF;
      i          <= 6'd0;
      ptr        <= 6'd0;
      remaining  <= 6'd0;
      card       <= 6'd0;
      card_valid <= 1'b0;
      ready      <= 1'b0;
      empty      <= 1'b0;
    end else begin
      // The LFSR free-runs in every state, so the shuffle depends on how long
      // the deck sat in IDLE before a reshuffle.
      lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      card_valid <= 1'b0;

      case (state)
        ST_INIT: begin
          if (i == LAST_IDX) begin
`ifdef DEALER_FIXED_DECK_EN
            state     <= ST_IDLE;
            ptr       <= 6'd0;
            remaining <= FULL_CNT;
            ready     <= 1'b1;
            empty     <= 1'b0;
`else
            // i stays at the last index: the shuffle walks downward from it.
            state     <= ST_SHUFFLE;
`endif
          end else begin
            i <= i + 6'd1;
          end
        end

        ST_SHUFFLE: begin
          if (i == 6'd1) begin
            state     <= ST_IDLE;
            ptr       <= 6'd0;
            remaining <= FULL_CNT;
            ready     <= 1'b1;
            empty     <= 1'b0;
          end else begin
            i <= i - 6'd1;
          end
        end

        ST_IDLE: begin
          if (shuffle_req) begin
            // Reshuffle takes priority over a same-cycle draw.
            state     <= ST_INIT;
            i         <= 6'd0;
            remaining <= 6'd0;
            ready     <= 1'b0;
            empty     <= 1'b0;
          end else if (draw_req && (remaining != 6'd0)) begin
            card       <= deck[ptr];
            card_valid <= 1'b1;
            ptr        <= ptr + 6'd1;
            remaining  <= remaining - 6'd1;
            // Flags for the post-deal count, so empty rises with the last strobe.
            ready      <= (remaining != 6'd1);
            empty      <= (remaining == 6'd1);
          end
        end

        default: begin
          state     <= ST_INIT;
          i         <= 6'd0;
          remaining <= 6'd0;
          ready     <= 1'b0;
          empty     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Deck source for the blackjack game. Builds a 52-card deck in internal storage, shuffles it with a Fisher-Yates pass driven by a free-running LFSR, then hands out one card per request without repetition until the deck is exhausted or reshuffled. Sits directly upstream of the blackjack round FSM, replacing fixed card lookup tables. Its card/rank outputs feed the player card and total registers.

## Interface
Parameters:
- DECK_SIZE, 52, number of cards; index range 0..DECK_SIZE-1.
- SEED, 16'hACE1, LFSR reset value. The value 0 is replaced by 16'h0001.

Ports:
- CLOCK_50  in  1  system clock; all state on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- shuffle_req  in  1  request rebuild and reshuffle. Level-sampled each cycle.
- draw_req  in  1  request one card. Level-sampled each cycle.
- card  out  6  dealt card index, 0..51.
- card_rank  out  4  card % 13, 0..12.
- card_suit  out  2  card / 13, 0..3.
- card_valid  out  1  one-cycle strobe; card/rank/suit are meaningful only in that cycle.
- ready  out  1  deck shuffled, at least one card left, state IDLE.
- remaining  out  6  cards not yet dealt.
- empty  out  1  state IDLE and remaining == 0.

## Operation
- Storage: deck[0..51], 6 bits each. Deal pointer ptr is 6 bits wide.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Loaded with SEED on reset, then advances every cycle in every state.
- States:
  - INIT: i counts 0→51 and writes deck[i]=i, one entry per cycle. After i=51, go to SHUFFLE with i=51.
  - SHUFFLE: one swap per cycle. j = (lfsr × (i+1)) >> 16, taken from bits [21:16] of the 22-bit product, so j is always in 0..i. Swap deck[i] and deck[j]; j==i is a legal no-op. After i=1, go to IDLE with ptr=0 and remaining=52.
  - IDLE, draw: draw_req=1 and remaining>0 → next cycle card=deck[ptr], card_valid=1, ptr+1, remaining−1.
  - IDLE, shuffle: shuffle_req=1 → go to INIT with i=0 and remaining=0.
- Simultaneous events:
  - shuffle_req and draw_req in the same IDLE cycle: shuffle wins, no card is dealt.
  - shuffle_req during INIT or SHUFFLE: ignored.
  - draw_req outside IDLE, or with remaining==0: ignored and not queued. card_valid stays 0.
- card holds its last dealt value between strobes. card_rank and card_suit are combinational from card.
- ready = (state==IDLE) && remaining>0.

## Timing
- Reset values: card=0, card_valid=0, ready=0, remaining=0, empty=0, state=INIT, i=0, ptr=0, lfsr=SEED.
- resetn asserted at any point, including mid-shuffle or mid-deal, immediately forces the reset values. Partial deck contents are don't-care because INIT rewrites every entry.
- From the first rising edge after resetn deasserts:
  - INIT occupies 52 cycles.
  - SHUFFLE occupies 51 cycles.
  - ready goes high after the 103rd edge.
- Draw latency is 1 cycle. draw_req held high in IDLE deals one card every cycle.
- After the 52nd card: remaining=0, ready=0 and empty=1 in the same cycle as that card's card_valid.
- Reshuffle from IDLE: ready drops the cycle after shuffle_req is sampled and returns 103 cycles later.

## Configuration
- DEALER_FIXED_DECK_EN
  - Defined: SHUFFLE is skipped. INIT goes straight to IDLE, the deck stays in identity order 0..51, and ready rises after 52 edges. Used for deterministic bring-up.
  - Undefined: full Fisher-Yates shuffle as described above.
  - Neither the LFSR nor the handshake changes.

## Test plan
- Reset, then release resetn: ready=0 for 102 edges, ready=1 after edge 103, remaining=52, empty=0. With DEALER_FIXED_DECK_EN, ready=1 after edge 52.
- DEALER_FIXED_DECK_EN, hold draw_req for 52 cycles → cards 0,1,…,51 on consecutive strobes. card 27 shows rank 1, suit 2. Ends with empty=1, remaining=0.
- Shuffled deck, draw all 52 cards → each index 0..51 appears exactly once. A 53rd draw_req gives no card_valid, and card keeps its last value.
- In IDLE with remaining=40, assert shuffle_req and draw_req in the same cycle → no card_valid, ready=0 next cycle, ready=1 with remaining=52 103 cycles later.
- Assert resetn low at SHUFFLE i=30 → all outputs return to reset values. The full 103-cycle sequence restarts and the resulting deck is a valid permutation.
- shuffle_req pulsed during INIT → ignored, and ready timing is unchanged.
